// File: rtl/stepper_pkg.sv
// stepper_pkg: shared constants and types for the stepper move controller.
package stepper_pkg;
  localparam int STEP_PHASES = 29;
  localparam int IDX_W = 5;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/stepper_phase_ring.sv
// stepper_phase_ring: bidirectional one-hot rotator with a tracked binary index.
module stepper_phase_ring
  import stepper_pkg::*;
#(
  parameter int PHASES = STEP_PHASES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              dir_i,
  output logic [PHASES-1:0] phase_o,
  output logic [IDX_W-1:0]  idx_o
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PHASES - 1);
  logic [PHASES-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  always_comb begin
    phase_d = !en_i ? phase_q :
              (dir_i == DIR_FWD) ? {phase_q[PHASES-2:0], phase_q[PHASES-1]} :
                                   {phase_q[0], phase_q[PHASES-1:1]};
    idx_d = !en_i ? idx_q :
            (dir_i == DIR_FWD) ? ((idx_q == LAST) ? '0 : idx_q + IDX_W'(1)) :
                                 ((idx_q == '0) ? LAST : idx_q - IDX_W'(1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PHASES'(1);
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end
  assign phase_o = phase_q;
  assign idx_o   = idx_q;
endmodule

// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl: accepts move commands, paces steps with a divider and drives the phase ring.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int PHASES = STEP_PHASES,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              step_pulse,
  output logic              dir,
  output logic [PHASES-1:0] phase,
  output logic [IDX_W-1:0]  phase_idx,
  output logic [CNT_W-1:0]  steps_left
);
  state_e           state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d, period_q, period_d, period_eff;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             dir_q, dir_d, done_q, done_d, aborted_q, aborted_d, step_q, step_d;
  logic             accept, running, abort_now, step_due, last_step;
  assign cmd_ready = (state_q == IDLE) && rst_n;
  always_comb begin
    accept     = cmd_valid && cmd_ready;
    running    = state_q == RUN;
    period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
    // abort wins over a step falling on the same edge
    abort_now  = running && abort;
    step_due   = running && !abort && (timer_q == DIV_W'(1));
    last_step  = step_due && (steps_q == CNT_W'(1));
    state_d    = running ? ((abort_now || last_step) ? IDLE : RUN) :
                           ((accept && cmd_steps != '0) ? RUN : IDLE);
    timer_d    = accept ? period_eff : !running ? timer_q :
                 step_due ? period_q : timer_q - DIV_W'(1);
    period_d   = accept ? period_eff : period_q;
    steps_d    = accept ? cmd_steps : step_due ? steps_q - CNT_W'(1) : steps_q;
    dir_d      = accept ? cmd_dir : dir_q;
    done_d     = (accept && cmd_steps == '0) || abort_now || last_step;
    aborted_d  = abort_now;
    step_d     = step_due;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      period_q  <= '0;
      steps_q   <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      steps_q   <= steps_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      step_q    <= step_d;
    end
  end
  stepper_phase_ring #(.PHASES(PHASES)) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (step_due),
    .dir_i   (dir_q),
    .phase_o (phase),
    .idx_o   (phase_idx)
  );
  assign busy       = state_q == RUN;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign step_pulse = step_q;
  assign dir        = dir_q;
  assign steps_left = steps_q;
endmodule
